arithmetic: RTL and testbench



---
 rtl/arithmetic_if.sv | 42 ++++
 rtl/arithmetic.sv | 133 +++++++++++++
 tb/tb_arithmetic.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arithmetic_if.sv
// Opcode/type package and the operand/result bundle of the execute-stage arithmetic unit.
// The package lives here so the interface and the unit share one opcode definition.
package instructions;
  typedef logic [63:0] ulong_t;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    MUL  = 4'd3,
    UDIV = 4'd4,
    UMOD = 4'd5,
    SDIV = 4'd6,
    SMOD = 4'd7,
    INC  = 4'd8,
    DEC  = 4'd9
  } opcode_t;
endpackage

interface arithmetic_if #(
  parameter int unsigned WIDTH = 64
);
  import instructions::*;

  opcode_t            op;
  logic               carryIn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   result;
  logic               divByZero;
  logic               carry;

  modport master (
    output op, carryIn, a, b,
    input  result, divByZero, carry
  );

  modport slave (
    input  op, carryIn, a, b,
    output result, divByZero, carry
  );
endinterface

// File: rtl/arithmetic.sv
// 64-bit integer arithmetic unit: add/sub/mul/div/mod/inc/dec with carry and
// divide-by-zero flags, all results registered one clock after operand capture.
module arithmetic #(
  parameter int unsigned WIDTH = 64
) (
  input  logic        clk,
  input  logic        resetN,
  arithmetic_if.slave bus
);
  import instructions::*;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_dividend;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_sq;
  logic [WIDTH-1:0]   w_sr;
  logic               w_b_zero;

  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_dbz;

  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_dbz;

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.carryIn};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.carryIn};
  assign w_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // One unsigned divider serves both flavours: signed ops divide magnitudes and
  // fix the signs afterwards, which also yields MIN/-1 = MIN without a special case.
  assign w_a_neg     = bus.a[WIDTH-1];
  assign w_b_neg     = bus.b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag     = w_b_neg ? (~bus.b + 1'b1) : bus.b;
  assign w_signed_op = (bus.op == SDIV) || (bus.op == SMOD);
  assign w_dividend  = w_signed_op ? w_a_mag : bus.a;
  assign w_divisor   = w_signed_op ? w_b_mag : bus.b;
  assign w_b_zero    = (bus.b == '0);

  always_comb begin
    w_uq = '0;
    w_ur = '0;
    if (!w_b_zero) begin
      w_uq = w_dividend / w_divisor;
      w_ur = w_dividend % w_divisor;
    end
  end

  assign w_sq = (w_a_neg ^ w_b_neg) ? (~w_uq + 1'b1) : w_uq;
  assign w_sr = w_a_neg ? (~w_ur + 1'b1) : w_ur;

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_dbz    = 1'b0;
    unique case (bus.op)
      ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_carry  = w_diff[WIDTH];
      end
      MUL: begin
        w_result = w_prod[WIDTH-1:0];
        w_carry  = |w_prod[2*WIDTH-1:WIDTH];
      end
      UDIV: begin
        w_dbz    = w_b_zero;
        w_result = w_uq;
      end
      UMOD: begin
        w_dbz    = w_b_zero;
        w_result = w_ur;
      end
      SDIV: begin
        w_dbz = w_b_zero;
        if (!w_b_zero) begin
          w_result = w_sq;
          w_carry  = w_sq[WIDTH-1];
        end
      end
      SMOD: begin
        w_dbz = w_b_zero;
        if (!w_b_zero) begin
          w_result = w_sr;
          w_carry  = w_sr[WIDTH-1];
        end
      end
      INC: begin
        w_result = bus.a + 1'b1;
        w_carry  = &bus.a;
      end
      DEC: begin
        w_result = bus.a - 1'b1;
        w_carry  = (bus.a == '0);
      end
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
        w_dbz    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_carry  <= w_carry;
      r_dbz    <= w_dbz;
    end
  end

  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.divByZero = r_dbz;
endmodule

// File: tb/tb_arithmetic.sv
// Directed bench for the arithmetic unit: hand-computed vectors checked one edge after issue.
module tb_arithmetic;
  import instructions::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic clk;
  logic resetN;
  int   checks;
  int   failures;

  arithmetic_if #(.WIDTH(64)) bus ();

  arithmetic #(.WIDTH(64)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] er, input logic ec, input logic ed);
    checks++;
    assert (bus.result === er) else begin
      failures++;
      $error("FAIL %s result: got %h want %h", tag, bus.result, er);
    end
    checks++;
    assert (bus.carry === ec) else begin
      failures++;
      $error("FAIL %s carry: got %b want %b", tag, bus.carry, ec);
    end
    checks++;
    assert (bus.divByZero === ed) else begin
      failures++;
      $error("FAIL %s divByZero: got %b want %b", tag, bus.divByZero, ed);
    end
  endtask

  task automatic drive(input opcode_t op, input logic cin, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.op      = op;
    bus.carryIn = cin;
    bus.a       = a;
    bus.b       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input opcode_t op, input logic cin,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] er, input logic ec, input logic ed);
    drive(op, cin, a, b);
    check(tag, er, ec, ed);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetN      = 1'b0;
    bus.op      = ADD;
    bus.carryIn = 1'b0;
    bus.a       = 64'd1;
    bus.b       = 64'd2;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("reset_released_before_edge", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first_capture", 64'd3, 1'b0, 1'b0);

    step("add_wrap_cin",   ADD, 1'b1, 64'd1, ONES - 64'd1, 64'd0, 1'b1, 1'b0);
    step("add_ones_cin",   ADD, 1'b1, ONES, 64'd1, 64'd1, 1'b1, 1'b0);
    step("sub_borrow",     SUB, 1'b1, 64'd3, 64'd3, ONES, 1'b1, 1'b0);
    step("sub_neg",        SUB, 1'b1, ONES - 64'd1, 64'd1, ONES - 64'd3, 1'b0, 1'b0);
    step("sub_equal",      SUB, 1'b0, ONES - 64'd1, ONES - 64'd1, 64'd0, 1'b0, 1'b0);

    step("mul_cin0",       MUL, 1'b0, 64'd2, 64'd3, 64'd6, 1'b0, 1'b0);
    step("mul_cin1",       MUL, 1'b1, 64'd2, 64'd3, 64'd6, 1'b0, 1'b0);
    step("mul_overflow",   MUL, 1'b0, 64'd2, ONES, ONES - 64'd1, 1'b1, 1'b0);

    step("udiv_half",      UDIV, 1'b0, ONES - 64'd1, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step("udiv_self",      UDIV, 1'b0, ONES - 64'd1, ONES - 64'd1, 64'd1, 1'b0, 1'b0);
    step("sdiv_neg",       SDIV, 1'b0, 64'd6, ONES - 64'd1, ONES - 64'd2, 1'b1, 1'b0);
    step("sdiv_min_m1",    SDIV, 1'b0, MIN, ONES, MIN, 1'b1, 1'b0);
    step("sdiv_zero_cin1", SDIV, 1'b1, 64'd5, 64'd0, 64'd0, 1'b0, 1'b1);
    step("udiv_zero_cin0", UDIV, 1'b0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b1);
    step("udiv_zero_cin1", UDIV, 1'b1, ONES, 64'd0, 64'd0, 1'b0, 1'b1);

    step("umod_big_b",     UMOD, 1'b0, 64'd4, ONES - 64'd2, 64'd4, 1'b0, 1'b0);
    step("umod_odd",       UMOD, 1'b0, ONES - 64'd4, 64'd2, 64'd1, 1'b0, 1'b0);
    step("smod_pos",       SMOD, 1'b0, 64'd4, ONES - 64'd2, 64'd1, 1'b0, 1'b0);
    step("smod_neg",       SMOD, 1'b0, ONES - 64'd4, 64'd2, ONES, 1'b1, 1'b0);
    step("smod_min_m1",    SMOD, 1'b0, MIN, ONES, 64'd0, 1'b0, 1'b0);
    step("umod_zero",      UMOD, 1'b0, 64'd9, 64'd0, 64'd0, 1'b0, 1'b1);
    step("smod_zero",      SMOD, 1'b1, ONES, 64'd0, 64'd0, 1'b0, 1'b1);

    step("inc_small",      INC, 1'b1, 64'd2, 64'd5, 64'd3, 1'b0, 1'b0);
    step("inc_wrap",       INC, 1'b0, ONES, 64'd0, 64'd0, 1'b1, 1'b0);
    step("dec_small",      DEC, 1'b0, 64'd2, 64'd8, 64'd1, 1'b0, 1'b0);
    step("dec_wrap",       DEC, 1'b1, 64'd0, 64'd3, ONES, 1'b1, 1'b0);
    step("nop",            NOP, 1'b1, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0);
    step("illegal_op",     opcode_t'(4'hF), 1'b1, ONES, ONES, 64'd0, 1'b0, 1'b0);

    // Mid-stream asynchronous reset must clear outputs without waiting for an edge.
    step("pre_reset_add",  ADD, 1'b0, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.op = ADD;
    bus.a  = 64'd4;
    bus.b  = 64'd5;
    resetN = 1'b1;
    #1;
    check("post_reset_hold", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_capture", 64'd9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
